// File: rtl/data_checker.sv
// Read-back data checker: compares DRAM read words against the generator's validation stream.
// Optional first-mismatch data capture is enabled by defining DATA_CHECKER_CAPTURE_EN.
module data_checker #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [COUNT_WIDTH-1:0]   i_num_words,
  input  logic                     i_rd_valid,
  input  logic [DATA_WIDTH-1:0]    i_rd_data,
  input  logic [DATA_WIDTH-1:0]    i_validation_data,
  output logic                     o_get_validation_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [COUNT_WIDTH-1:0]   o_err_count,
  output logic [DATA_WIDTH/64-1:0] o_lane_err,
  output logic [COUNT_WIDTH-1:0]   o_first_err_index,
`ifdef DATA_CHECKER_CAPTURE_EN
  output logic [DATA_WIDTH-1:0]    o_first_err_got,
  output logic [DATA_WIDTH-1:0]    o_first_err_exp,
`endif
  output logic [COUNT_WIDTH-1:0]   o_word_count
);

  localparam int unsigned Lanes = DATA_WIDTH / 64;
  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [COUNT_WIDTH-1:0] r_num_words;
  logic [COUNT_WIDTH-1:0] r_word_count;
  logic [COUNT_WIDTH-1:0] r_err_count;
  logic [COUNT_WIDTH-1:0] r_first_err_index;
  logic [Lanes-1:0]       r_lane_err;
`ifdef DATA_CHECKER_CAPTURE_EN
  logic [DATA_WIDTH-1:0]  r_first_err_got;
  logic [DATA_WIDTH-1:0]  r_first_err_exp;
`endif

  logic             w_accept;
  logic             w_last;
  logic             w_any_diff;
  logic [Lanes-1:0] w_lane_diff;

  always_comb begin
    w_lane_diff = '0;
    for (int l = 0; l < Lanes; l++) begin
      w_lane_diff[l] = |(i_rd_data[l*64 +: 64] ^ i_validation_data[l*64 +: 64]);
    end
  end

  assign w_any_diff = |w_lane_diff;
  assign w_accept   = (r_state == StRun) && i_rd_valid;
  assign w_last     = (r_word_count == (r_num_words - CntOne));

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state           <= StIdle;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_error           <= 1'b0;
      r_num_words       <= '0;
      r_word_count      <= '0;
      r_err_count       <= '0;
      r_first_err_index <= '0;
      r_lane_err        <= '0;
`ifdef DATA_CHECKER_CAPTURE_EN
      r_first_err_got   <= '0;
      r_first_err_exp   <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_num_words       <= i_num_words;
            r_word_count      <= '0;
            r_err_count       <= '0;
            r_error           <= 1'b0;
            r_lane_err        <= '0;
            r_first_err_index <= '0;
`ifdef DATA_CHECKER_CAPTURE_EN
            r_first_err_got   <= '0;
            r_first_err_exp   <= '0;
`endif
            // A zero-length run completes immediately with empty results.
            if (i_num_words == '0) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (w_accept) begin
            r_word_count <= r_word_count + CntOne;
            if (w_any_diff) begin
              if (!(&r_err_count)) begin
                r_err_count <= r_err_count + CntOne;
              end
              r_error    <= 1'b1;
              r_lane_err <= r_lane_err | w_lane_diff;
              if (!r_error) begin
                r_first_err_index <= r_word_count;
`ifdef DATA_CHECKER_CAPTURE_EN
                r_first_err_got   <= i_rd_data;
                r_first_err_exp   <= i_validation_data;
`endif
              end
            end
            if (w_last) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_get_validation_data = w_accept;
  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_error               = r_error;
  assign o_err_count           = r_err_count;
  assign o_lane_err            = r_lane_err;
  assign o_first_err_index     = r_first_err_index;
  assign o_word_count          = r_word_count;
`ifdef DATA_CHECKER_CAPTURE_EN
  assign o_first_err_got       = r_first_err_got;
  assign o_first_err_exp       = r_first_err_exp;
`endif

endmodule

// File: tb/tb_data_checker.sv
// Scoreboard bench for data_checker; a behavioural generator model supplies the validation stream.
module tb_data_checker;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [CW-1:0] i_num_words;
  logic          i_rd_valid;
  logic [DW-1:0] i_rd_data;
  logic [DW-1:0] i_validation_data;
  logic          o_get_validation_data;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [CW-1:0] o_err_count;
  logic [1:0]    o_lane_err;
  logic [CW-1:0] o_first_err_index;
  logic [CW-1:0] o_word_count;
`ifdef DATA_CHECKER_CAPTURE_EN
  logic [DW-1:0] o_first_err_got;
  logic [DW-1:0] o_first_err_exp;
`endif

  data_checker #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) u_dut (
    .clk                   (clk),
    .i_rst                 (i_rst),
    .i_start               (i_start),
    .i_num_words           (i_num_words),
    .i_rd_valid            (i_rd_valid),
    .i_rd_data             (i_rd_data),
    .i_validation_data     (i_validation_data),
    .o_get_validation_data (o_get_validation_data),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_error               (o_error),
    .o_err_count           (o_err_count),
    .o_lane_err            (o_lane_err),
    .o_first_err_index     (o_first_err_index),
`ifdef DATA_CHECKER_CAPTURE_EN
    .o_first_err_got       (o_first_err_got),
    .o_first_err_exp       (o_first_err_exp),
`endif
    .o_word_count          (o_word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] gen_word(input int unsigned idx);
    logic [31:0] v;
    v = idx;
    return {v ^ 32'hDEAD_BEEF, v * 32'h9E37_79B9, ~v, v + 32'h0101_0101};
  endfunction

  // Generator model: advances one word per get pulse.
  int unsigned gen_idx;
  always @(posedge clk or posedge i_rst) begin
    if (i_rst) gen_idx <= 0;
    else if (o_get_validation_data) gen_idx <= gen_idx + 1;
  end
  assign i_validation_data = gen_word(gen_idx);

  typedef struct packed {
    logic [CW-1:0] wc;
    logic [CW-1:0] ec;
    logic [1:0]    lane;
    logic          err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_get    = 0;
  int unsigned drv_idx  = 0;
  logic [CW-1:0] m_wc, m_ec, m_first;
  logic [1:0]    m_lane;
  logic          m_err;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every get pulse pops one expected post-edge result.
  initial begin : monitor
    exp_t e;
    logic seen;
    forever begin
      @(negedge clk);
      seen = o_get_validation_data;
      if (seen) n_get++;
      @(posedge clk);
      #2;
      if (seen) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 0, 1);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_word_count", o_word_count, e.wc);
          check_eq("sb_err_count", o_err_count, e.ec);
          check_eq("sb_lane_err", o_lane_err, e.lane);
          check_eq("sb_error", o_error, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [CW-1:0] n);
    i_start     = 1'b1;
    i_num_words = n;
    tick();
    i_start = 1'b0;
    m_wc = '0; m_ec = '0; m_first = '0; m_lane = '0; m_err = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] mask);
    logic [1:0] diff;
    exp_t e;
    diff = {|mask[127:64], |mask[63:0]};
    i_rd_valid = 1'b1;
    i_rd_data  = gen_word(drv_idx) ^ mask;
    if (diff != 2'b00) begin
      if (!m_err) m_first = m_wc;
      m_ec   = m_ec + 1;
      m_err  = 1'b1;
      m_lane = m_lane | diff;
    end
    m_wc = m_wc + 1;
    e.wc = m_wc; e.ec = m_ec; e.lane = m_lane; e.err = m_err;
    sb_q.push_back(e);
    drv_idx++;
    tick();
    i_rd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_error"}, o_error, 0);
    check_eq({tag, "_err_count"}, o_err_count, 0);
    check_eq({tag, "_lane_err"}, o_lane_err, 0);
    check_eq({tag, "_first_idx"}, o_first_err_index, 0);
    check_eq({tag, "_word_count"}, o_word_count, 0);
    check_eq({tag, "_get"}, o_get_validation_data, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int g0;
    logic [DW-1:0] mask;
    logic [DW-1:0] cap_got, cap_exp;
    i_rst = 1'b1; i_start = 1'b0; i_num_words = '0; i_rd_valid = 1'b1; i_rd_data = '0;
    #3;
    check_zero("reset");
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_rd_valid = 1'b0;
    tick();

    // Clean back-to-back run
    g0 = n_get;
    start_run(16);
    check_eq("clean_busy", o_busy, 1);
    for (int w = 0; w < 15; w++) send('0);
    check_eq("clean_not_done_early", o_done, 0);
    send('0);
    check_eq("clean_done", o_done, 1);
    check_eq("clean_busy_off", o_busy, 0);
    check_eq("clean_error", o_error, 0);
    check_eq("clean_err_count", o_err_count, 0);
    check_eq("clean_word_count", o_word_count, 16);
    idle(2);
    check_eq("clean_get_pulses", n_get - g0, 16);

    // rd_valid outside RUN is ignored
    i_rd_valid = 1'b1;
    #3;
    check_eq("done_no_get", o_get_validation_data, 0);
    idle(2);
    i_rd_valid = 1'b0;
    check_eq("done_hold_wc", o_word_count, 16);
    check_eq("done_hold_done", o_done, 1);

    // Injected errors with gaps
    start_run(8);
    for (int w = 0; w < 8; w++) begin
      mask = '0;
      if (w == 3) mask[70] = 1'b1;
      if (w == 5) mask[0] = 1'b1;
      if (w == 3) begin
        cap_exp = gen_word(drv_idx);
        cap_got = cap_exp ^ mask;
      end
      send(mask);
      if (w != 7) idle(1 + (w % 2));
    end
    check_eq("err_done", o_done, 1);
    check_eq("err_count", o_err_count, 2);
    check_eq("err_first_idx", o_first_err_index, m_first);
    check_eq("err_first_idx_3", o_first_err_index, 3);
    check_eq("err_lane", o_lane_err, 2'b11);
    check_eq("err_flag", o_error, 1);
`ifdef DATA_CHECKER_CAPTURE_EN
    check_eq("cap_got", o_first_err_got, cap_got);
    check_eq("cap_exp", o_first_err_exp, cap_exp);
`endif

    // Zero length
    g0 = n_get;
    start_run(0);
    check_eq("zero_done", o_done, 1);
    check_eq("zero_busy", o_busy, 0);
    check_eq("zero_err_count", o_err_count, 0);
    check_eq("zero_error", o_error, 0);
    check_eq("zero_lane", o_lane_err, 0);
    check_eq("zero_wc", o_word_count, 0);
    idle(2);
    check_eq("zero_get_pulses", n_get - g0, 0);

    // Start during RUN is ignored; a restart from DONE clears results
    start_run(4);
    mask = '0; mask[127] = 1'b1;
    send(mask);
    send('0);
    i_start = 1'b1; i_num_words = 100;
    tick();
    i_start = 1'b0;
    check_eq("ign_busy", o_busy, 1);
    send('0);
    send('0);
    check_eq("ign_done", o_done, 1);
    check_eq("ign_wc", o_word_count, 4);
    check_eq("ign_lane", o_lane_err, 2'b10);
    start_run(3);
    check_eq("restart_done_clr", o_done, 0);
    check_eq("restart_busy", o_busy, 1);
    check_eq("restart_error_clr", o_error, 0);
    check_eq("restart_ec_clr", o_err_count, 0);
    check_eq("restart_lane_clr", o_lane_err, 0);
    check_eq("restart_wc_clr", o_word_count, 0);
`ifdef DATA_CHECKER_CAPTURE_EN
    check_eq("restart_cap_clr", o_first_err_got, 0);
`endif
    for (int w = 0; w < 3; w++) send('0);
    check_eq("restart_done", o_done, 1);
    check_eq("restart_wc", o_word_count, 3);

    // Reset mid-run
    start_run(10);
    for (int w = 0; w < 5; w++) send('0);
    i_rd_valid = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_rd_valid = 1'b0;
    drv_idx = 0;
    sb_q.delete();
    idle(3);
    check_eq("midrst_no_done", o_done, 0);
    check_eq("midrst_wc", o_word_count, 0);
    start_run(3);
    for (int w = 0; w < 3; w++) send('0);
    check_eq("post_rst_done", o_done, 1);
    check_eq("post_rst_wc", o_word_count, 3);
    check_eq("post_rst_error", o_error, 0);
    idle(2);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_checker.md
Name: data_checker

Overview:
- Consumer-side counterpart of the write/validation data generator in the DRAM test path.
- Accepts read-back words from the DRAM controller and compares each against the expected word on the generator's validation stream.
- Advances that stream one word per accepted read.
- Reports pass/fail, error count, per-64-bit-lane error bitmap and first failing word index to the test controller.

Parameters:
DATA_WIDTH, 128, read/validation word width; multiple of 64
COUNT_WIDTH, 32, width of word-count and error-count registers

Ports:
clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_start  in  1  one-cycle pulse; begins a check run
i_num_words  in  COUNT_WIDTH  words to check; sampled on accepted i_start
i_rd_valid  in  1  read-back word present this cycle
i_rd_data  in  DATA_WIDTH  read-back word
i_validation_data  in  DATA_WIDTH  current expected word from generator
o_get_validation_data  out  1  advance generator; pulse per consumed word
o_busy  out  1  run in progress
o_done  out  1  run finished (level, held until next start or reset)
o_error  out  1  sticky: any mismatch in current/last run
o_err_count  out  COUNT_WIDTH  mismatching words, saturating
o_lane_err  out  DATA_WIDTH/64  sticky per-64-bit-lane mismatch bitmap
o_first_err_index  out  COUNT_WIDTH  0-based index of first mismatching word
o_word_count  out  COUNT_WIDTH  words consumed in current run

Behaviour:
- Clock and reset: single clock clk; i_rst is asynchronous and active-high.
- Reset:
  - State goes to IDLE.
  - All outputs and internal registers are 0.
  - Reset mid-run aborts the run with no done indication.
- States:
  - IDLE: i_start && i_num_words!=0 -> RUN. i_start && i_num_words==0 -> DONE with zero results.
  - RUN: o_busy=1.
  - DONE: o_done=1. i_start -> RUN or DONE by the same rule as IDLE.
- Run start:
  - On an accepted start: latch i_num_words.
  - Clear o_word_count, o_err_count, o_error, o_lane_err and o_first_err_index.
  - Deassert o_done.
- i_start while in RUN is ignored.
- Accepting a word (RUN && i_rd_valid):
  - o_get_validation_data = RUN && i_rd_valid, combinationally in the same cycle. The generator therefore presents the next expected word from the following cycle.
  - Compare i_rd_data with i_validation_data per 64-bit lane in the same cycle.
  - Registered updates at the clock edge:
    - o_word_count += 1.
    - Any lane differs: o_err_count += 1, saturating at all-ones; o_error <= 1; o_lane_err |= differing lanes.
    - First mismatch of the run: o_first_err_index <= index of the word, i.e. the o_word_count value before increment.
- End of run:
  - When the accepted word is number latched_num-1, go to DONE at that edge.
  - o_done is visible the cycle after the last accept, with final counts.
- Outside RUN:
  - i_rd_valid is ignored.
  - o_get_validation_data stays 0.
  - No counters change.
- Back-to-back: i_rd_valid may be high every cycle; throughput is 1 word/cycle with no stalls.
- o_word_count wrap is impossible, since a run ends at latched_num ≤ 2^COUNT_WIDTH-1.
- Results hold in DONE until the next accepted start or reset.

Optional Feature:
- Macro: DATA_CHECKER_CAPTURE_EN.
- When defined:
  - Extra ports o_first_err_got and o_first_err_exp, both DATA_WIDTH.
  - They register i_rd_data and i_validation_data at the first mismatch of a run.
  - Cleared to 0 on reset and on an accepted start.
- When undefined:
  - The ports do not exist.
  - No capture registers are synthesised.

Test Plan:
- Reset values: reset asserted asynchronously mid-cycle -> all outputs 0 immediately; state IDLE; o_get_validation_data 0 even with i_rd_valid=1.
- Clean run:
  - Stimulus: start, num=16, 16 consecutive valid words equal to the bench model stream.
  - Response: 16 get pulses; o_done 1 cycle after the last accept; o_error=0; o_err_count=0; o_word_count=16.
- Injected errors:
  - Stimulus: num=8; word 3 bit 70 flipped; word 5 bit 0 flipped; valid gaps between words.
  - Response: o_err_count=2; o_first_err_index=3; o_lane_err=2'b11; o_error=1.
  - With capture enabled: o_first_err_got/exp show the word-3 data pair.
- Zero length: start with num=0 -> DONE next cycle; no get pulses; counts 0.
- Restart and ignored start:
  - Stimulus: i_start pulsed during RUN, then a second run started from DONE.
  - Response: the pulse in RUN has no effect. The second run clears all results before counting.
- Reset mid-run: i_rst after 5 of 10 words -> outputs 0; o_done never asserted; a subsequent start runs normally.
